ahb_slave_phase_mux: RTL and testbench
======================================

// Module: ahb_slave_phase_mux
// PURPOSE
//  Slave-side AHB interconnect mux, successor to the one-hot combinational payload mux.
//  Splits each master channel into an address-phase payload and a write-data payload.
//  Address phase is selected by the current grant; write data by the grant registered for the data phase.
//  Non-one-hot grants are trapped and counted. Sits between the arbiter and one slave port.
// PARAMETERS
//  CHANNEL_NUM  4   number of master channels, 1..16
//  ADDR_PL_W    45  address-phase payload width: HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4
//  DATA_W       32  HWDATA width
//  HTRANS_LSB   0   bit position of HTRANS[0] inside the address payload
//  ERR_CNT_W    8   width of the saturating illegal-select counter
// PORTS
//  HCLK          in   1                       AHB clock
//  HRESETn       in   1                       async active-low reset
//  addr_pl_in    in   CHANNEL_NUM*ADDR_PL_W   packed address payloads, channel i at [i]
//  wdata_in      in   CHANNEL_NUM*DATA_W      packed HWDATA, channel i at [i]
//  sel           in   CHANNEL_NUM             one-hot grant from the arbiter, address phase
//  hready_in     in   1                       HREADY from the slave/default slave
//  addr_pl_out   out  ADDR_PL_W               selected address payload, to the slave
//  wdata_out     out  DATA_W                  selected data-phase HWDATA, to the slave
//  data_owner    out  CHANNEL_NUM             one-hot owner of the current data phase
//  data_active   out  1                       a data phase is in progress
//  illegal_sel   out  1                       1-cycle pulse: sel had more than one bit set (sampled on hready_in)
//  err_cnt       out  ERR_CNT_W               saturating count of illegal_sel events
// BEHAVIOUR
//  Reset: data_owner=0, data_active=0, illegal_sel=0, err_cnt=0, FSM=D_IDLE.
//   Combinational outputs follow these values: wdata_out=0; addr_pl_out tracks sel.
//  Address mux, combinational, 0 latency:
//   - sel exactly one-hot, bit i -> addr_pl_out = addr_pl_in[i].
//   - sel==0 -> addr_pl_out = 0, so HTRANS=IDLE.
//   - sel multi-hot -> addr_pl_out = 0 (forced IDLE transfer).
//  Data mux, combinational from the data_owner register: wdata_out = wdata_in[owner]; 0 when data_owner==0.
//  FSM, 2 states, advances only on HCLK edges where hready_in=1; all state is held while hready_in=0:
//   D_IDLE -> D_ACTIVE   if sel is one-hot and the selected HTRANS is NONSEQ or SEQ.
//   D_ACTIVE -> D_ACTIVE same condition; data_owner reloads (back-to-back, including an owner change).
//   D_ACTIVE -> D_IDLE   otherwise (IDLE/BUSY, sel==0, multi-hot); data_owner cleared to 0.
//   data_active = (state==D_ACTIVE); data_owner is loaded with sel on entry and reload.
//  Wait states: hready_in=0 holds data_owner, wdata_out and the state, even if sel changes.
//  Illegal select: on an HCLK edge with hready_in=1 and popcount(sel)>1:
//   - illegal_sel=1 on the next cycle;
//   - err_cnt += 1, saturating at 2^ERR_CNT_W-1;
//   - no data phase is claimed.
//  Multi-hot sel while hready_in=0 is neither counted nor flagged.
//  Reset asserted mid-transfer clears all state immediately, asynchronously.
//   First post-reset edge behaves as from D_IDLE.
// STRUCTURE
//  AHB_package: htrans_t enum, constants HTRANS_IDLE/BUSY/NONSEQ/SEQ, and function onehot_ok() (exactly one bit set).
//  Sub-module ahb_onehot2bin: one-hot -> binary index plus valid/multi flags.
//   Used for both sel and data_owner indexing.
//  Top level holds the FSM, registers and the two mux arrays.
// TESTING
//  1. Reset, then sel=4'b0010 with ch1 HTRANS=NONSEQ, hready=1.
//     -> addr_pl_out=ch1 the same cycle; next cycle data_owner=0010, wdata_out=ch1 data.
//  2. Back-to-back: ch1 NONSEQ, then ch2 NONSEQ, hready=1.
//     -> data phase of cycle 2 shows ch1 wdata while addr_pl_out already shows ch2.
//  3. Wait states: hready=0 for 3 cycles during a ch3 data phase while sel changes.
//     -> data_owner=1000 and wdata_out=ch3 held throughout.
//  4. sel=4'b0110, hready=1.
//     -> addr_pl_out=0, illegal_sel pulses one cycle, err_cnt 0->1, data_active=0 next cycle.
//     -> 300 repeats with ERR_CNT_W=8 saturate err_cnt at 255.
//  5. sel=0 or HTRANS=IDLE/BUSY from D_ACTIVE -> D_IDLE, data_owner=0, wdata_out=0.
//  6. HRESETn low mid data phase -> all outputs reset immediately; after release, first NONSEQ handled normally.

Source files
------------

// File: rtl/ahb_slave_phase_mux_pkg.sv
// Shared types and helpers for the AHB slave-side phase mux.
//   htrans_t        : AHB HTRANS encoding
//   dphase_state_t  : data-phase tracker states
//   onehot_ok()     : true when exactly one bit of a (zero-extended) select is set
//   is_transfer()   : true for HTRANS values that open a data phase
package ahb_slave_phase_mux_pkg;

    localparam int MAX_CHANNELS = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        D_IDLE   = 1'b0,
        D_ACTIVE = 1'b1
    } dphase_state_t;

    function automatic logic onehot_ok(input logic [MAX_CHANNELS-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (vec[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic is_transfer(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_phase_mux_onehot2bin.sv
// One-hot to binary decoder with qualification flags.
//   i_onehot : select vector, N bits (N <= 16)
//   o_idx    : index of a set bit (meaningful only when exactly one is set)
//   o_valid  : at least one bit set
//   o_multi  : more than one bit set
module ahb_onehot2bin
    import ahb_slave_phase_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid,
    output logic             o_multi
);

    always_comb begin
        // NOTE: default assigned before the loop so every path drives o_idx and no latch is inferred.
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_valid = |i_onehot;
    assign o_multi = o_valid & ~onehot_ok(MAX_CHANNELS'(i_onehot));

endmodule

// File: rtl/ahb_slave_phase_mux.sv
// AHB slave-side interconnect mux with split address/data phases.
//   HCLK, HRESETn : clock, async active-low reset
//   addr_pl_in    : packed per-channel address payloads (HADDR/HTRANS/...)
//   wdata_in      : packed per-channel HWDATA
//   sel           : one-hot address-phase grant from the arbiter
//   hready_in     : HREADY from the slave side; qualifies every state update
//   addr_pl_out   : payload of the granted channel, zero if grant is not one-hot
//   wdata_out     : HWDATA of the data-phase owner, zero when no owner
//   data_owner    : one-hot owner of the current data phase
//   data_active   : a data phase is in progress
//   illegal_sel   : one-cycle pulse after a multi-hot grant was sampled
//   err_cnt       : saturating count of illegal grants
module ahb_slave_phase_mux
    import ahb_slave_phase_mux_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int ADDR_PL_W   = 45,
    parameter int DATA_W      = 32,
    parameter int HTRANS_LSB  = 0,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [CHANNEL_NUM*ADDR_PL_W-1:0] addr_pl_in,
    input  logic [CHANNEL_NUM*DATA_W-1:0]    wdata_in,
    input  logic [CHANNEL_NUM-1:0]           sel,
    input  logic                             hready_in,
    output logic [ADDR_PL_W-1:0]             addr_pl_out,
    output logic [DATA_W-1:0]                wdata_out,
    output logic [CHANNEL_NUM-1:0]           data_owner,
    output logic                             data_active,
    output logic                             illegal_sel,
    output logic [ERR_CNT_W-1:0]             err_cnt
);

    localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    logic [ADDR_PL_W-1:0]   w_addr_ch  [CHANNEL_NUM];
    logic [DATA_W-1:0]      w_wdata_ch [CHANNEL_NUM];

    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_sel_valid;
    logic                   w_sel_multi;
    logic                   w_sel_onehot;
    logic [IDX_W-1:0]       w_owner_idx;
    logic                   w_owner_valid;
    logic                   w_owner_multi;
    logic                   w_owner_onehot;
    logic [ADDR_PL_W-1:0]   w_sel_pl;
    htrans_t                w_sel_htrans;
    logic                   w_claim;

    dphase_state_t          r_state;
    dphase_state_t          w_state_nxt;
    logic [CHANNEL_NUM-1:0] r_data_owner;
    logic [CHANNEL_NUM-1:0] w_owner_nxt;
    logic                   r_illegal_sel;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_unpack
        assign w_addr_ch[g]  = addr_pl_in[g*ADDR_PL_W +: ADDR_PL_W];
        assign w_wdata_ch[g] = wdata_in[g*DATA_W +: DATA_W];
    end

    ahb_onehot2bin #(.N(CHANNEL_NUM), .IDX_W(IDX_W)) u_sel_dec (
        .i_onehot (sel),
        .o_idx    (w_sel_idx),
        .o_valid  (w_sel_valid),
        .o_multi  (w_sel_multi)
    );

    ahb_onehot2bin #(.N(CHANNEL_NUM), .IDX_W(IDX_W)) u_owner_dec (
        .i_onehot (r_data_owner),
        .o_idx    (w_owner_idx),
        .o_valid  (w_owner_valid),
        .o_multi  (w_owner_multi)
    );

    assign w_sel_onehot   = w_sel_valid & ~w_sel_multi;
    assign w_owner_onehot = w_owner_valid & ~w_owner_multi;

    // Address phase: zero payload for no grant or a multi-hot grant, which
    // presents HTRANS=IDLE to the slave.
    assign w_sel_pl     = w_addr_ch[w_sel_idx];
    assign addr_pl_out  = w_sel_onehot ? w_sel_pl : '0;
    assign w_sel_htrans = htrans_t'(w_sel_pl[HTRANS_LSB +: 2]);
    assign w_claim      = w_sel_onehot && is_transfer(w_sel_htrans);

    // Data phase: driven from the registered owner, one cycle behind sel.
    assign wdata_out = w_owner_onehot ? w_wdata_ch[w_owner_idx] : '0;

    // The next data phase depends only on the sampled address phase, so both
    // states share one transition rule; hready_in low freezes everything.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_data_owner;
        if (hready_in) begin
            if (w_claim) begin
                w_state_nxt = D_ACTIVE;
                w_owner_nxt = sel;
            end else begin
                w_state_nxt = D_IDLE;
                w_owner_nxt = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= D_IDLE;
            r_data_owner  <= '0;
            r_illegal_sel <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            r_state       <= w_state_nxt;
            r_data_owner  <= w_owner_nxt;
            // Re-evaluated every edge so the flag is a single-cycle pulse.
            r_illegal_sel <= hready_in & w_sel_multi;
            if (hready_in && w_sel_multi && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign data_owner  = r_data_owner;
    assign data_active = (r_state == D_ACTIVE);
    assign illegal_sel = r_illegal_sel;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_ahb_slave_phase_mux.sv
module tb_ahb_slave_phase_mux;
    import ahb_slave_phase_mux_pkg::*;

    localparam int CH = 4;
    localparam int AW = 45;
    localparam int DW = 32;
    localparam int EW = 8;

    logic             HCLK;
    logic             HRESETn;
    logic [CH*AW-1:0] addr_pl_in;
    logic [CH*DW-1:0] wdata_in;
    logic [CH-1:0]    sel;
    logic             hready_in;
    logic [AW-1:0]    addr_pl_out;
    logic [DW-1:0]    wdata_out;
    logic [CH-1:0]    data_owner;
    logic             data_active;
    logic             illegal_sel;
    logic [EW-1:0]    err_cnt;

    logic [1:0]       htr [CH];

    typedef struct {
        string         nm;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [CH-1:0] owner;
        logic          active;
        logic          ill;
        logic [EW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ahb_slave_phase_mux #(
        .CHANNEL_NUM (CH),
        .ADDR_PL_W   (AW),
        .DATA_W      (DW),
        .HTRANS_LSB  (0),
        .ERR_CNT_W   (EW)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .addr_pl_in  (addr_pl_in),
        .wdata_in    (wdata_in),
        .sel         (sel),
        .hready_in   (hready_in),
        .addr_pl_out (addr_pl_out),
        .wdata_out   (wdata_out),
        .data_owner  (data_owner),
        .data_active (data_active),
        .illegal_sel (illegal_sel),
        .err_cnt     (err_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Fixed per-channel payloads: HADDR, HPROT, HBURST, HSIZE, HWRITE, HTRANS.
    function automatic logic [AW-1:0] mk_addr(input int ch, input logic [1:0] t);
        logic [31:0] haddr;
        haddr = 32'hA000_0010 + 32'(ch) * 32'h100;
        return {haddr, 4'h3, 3'b001, 3'b010, (ch % 2 == 1), t};
    endfunction

    function automatic logic [DW-1:0] mk_wdata(input int ch);
        return 32'hD000_0000 + 32'(ch) * 32'h1111;
    endfunction

    function automatic logic [DW-1:0] owner_data(input logic [CH-1:0] o);
        case (o)
            4'b0001: return mk_wdata(0);
            4'b0010: return mk_wdata(1);
            4'b0100: return mk_wdata(2);
            4'b1000: return mk_wdata(3);
            default: return '0;
        endcase
    endfunction

    for (genvar g = 0; g < CH; g++) begin : g_drv
        assign addr_pl_in[g*AW +: AW] = mk_addr(g, htr[g]);
        assign wdata_in[g*DW +: DW]   = mk_wdata(g);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show before
    // the next rising edge. Registered expectations reflect the previous cycle.
    task automatic step(input string nm, input logic [CH-1:0] s, input logic hr,
                        input int addr_ch, input logic [CH-1:0] eo,
                        input logic ea, input logic ei, input int ec);
        exp_t e;
        sel       = s;
        hready_in = hr;
        e.nm      = nm;
        if (addr_ch < 0) e.addr = '0;
        else             e.addr = mk_addr(addr_ch, htr[addr_ch]);
        e.owner   = eo;
        e.wdata   = owner_data(eo);
        e.active  = ea;
        e.ill     = ei;
        e.cnt     = ec[EW-1:0];
        sb.push_back(e);
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge HCLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, ".addr_pl_out"}, 64'(addr_pl_out), 64'(e.addr));
            check({e.nm, ".wdata_out"},   64'(wdata_out),   64'(e.wdata));
            check({e.nm, ".data_owner"},  64'(data_owner),  64'(e.owner));
            check({e.nm, ".data_active"}, 64'(data_active), 64'(e.active));
            check({e.nm, ".illegal_sel"}, 64'(illegal_sel), 64'(e.ill));
            check({e.nm, ".err_cnt"},     64'(err_cnt),     64'(e.cnt));
        end
    end

    initial begin
        HRESETn   = 1'b0;
        sel       = '0;
        hready_in = 1'b1;
        for (int i = 0; i < CH; i++) htr[i] = HTRANS_NONSEQ;
        @(posedge HCLK);
        #1;

        // Reset values; addr mux stays live during reset.
        step("rst_idle",        4'b0000, 1'b1, -1, 4'b0000, 0, 0, 0);
        step("rst_addr_tracks", 4'b0010, 1'b1,  1, 4'b0000, 0, 0, 0);
        HRESETn = 1'b1;

        // First NONSEQ, then back-to-back owner changes.
        step("t1_addr_ch1",     4'b0010, 1'b1,  1, 4'b0000, 0, 0, 0);
        step("t2_data_ch1",     4'b0100, 1'b1,  2, 4'b0010, 1, 0, 0);
        step("t2_data_ch2",     4'b1000, 1'b1,  3, 4'b0100, 1, 0, 0);

        // Three wait states during the ch3 data phase while sel moves around.
        step("t3_wait1",        4'b0001, 1'b0,  0, 4'b1000, 1, 0, 0);
        step("t3_wait2_multi",  4'b0110, 1'b0, -1, 4'b1000, 1, 0, 0);
        step("t3_wait3",        4'b0010, 1'b0,  1, 4'b1000, 1, 0, 0);
        step("t3_release",      4'b0000, 1'b1, -1, 4'b1000, 1, 0, 0);

        // IDLE/BUSY/SEQ handling.
        htr[0] = HTRANS_IDLE;
        step("t5_idle_addr",    4'b0001, 1'b1,  0, 4'b0000, 0, 0, 0);
        htr[0] = HTRANS_NONSEQ;
        step("t5_no_claim",     4'b0001, 1'b1,  0, 4'b0000, 0, 0, 0);
        htr[1] = HTRANS_BUSY;
        step("t5_busy_addr",    4'b0010, 1'b1,  1, 4'b0001, 1, 0, 0);
        htr[2] = HTRANS_SEQ;
        step("t5_busy_ends",    4'b0100, 1'b1,  2, 4'b0000, 0, 0, 0);
        htr[2] = HTRANS_IDLE;
        step("t5_seq_claims",   4'b0100, 1'b1,  2, 4'b0100, 1, 0, 0);
        step("t5_idle_ends",    4'b1000, 1'b1,  3, 4'b0000, 0, 0, 0);

        // Illegal select out of an active data phase.
        step("t4_multi",        4'b0110, 1'b1, -1, 4'b1000, 1, 0, 0);
        step("t4_pulse",        4'b0000, 1'b1, -1, 4'b0000, 0, 1, 1);
        step("t4_pulse_gone",   4'b0000, 1'b0, -1, 4'b0000, 0, 0, 1);

        // 300 more illegal grants saturate the counter at 255.
        for (int k = 0; k < 300; k++) begin
            step("t4_sat", 4'b1111, 1'b1, -1, 4'b0000, 0, (k > 0), ((1 + k) > 255) ? 255 : (1 + k));
        end
        step("t4_sat_end",      4'b0000, 1'b1, -1, 4'b0000, 0, 1, 255);
        step("t4_sat_hold",     4'b0000, 1'b1, -1, 4'b0000, 0, 0, 255);

        // Asynchronous reset in the middle of a ch1 data phase.
        htr[1] = HTRANS_NONSEQ;
        htr[2] = HTRANS_NONSEQ;
        step("t6_claim_ch1",    4'b0010, 1'b1,  1, 4'b0000, 0, 0, 255);
        HRESETn = 1'b0;
        step("t6_async_rst",    4'b0010, 1'b1,  1, 4'b0000, 0, 0, 0);
        HRESETn = 1'b1;
        step("t6_first_nonseq", 4'b0100, 1'b1,  2, 4'b0000, 0, 0, 0);
        step("t6_data_ch2",     4'b0000, 1'b1, -1, 4'b0100, 1, 0, 0);
        step("t6_back_idle",    4'b0000, 1'b1, -1, 4'b0000, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge HCLK);
            #1;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
